sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
Input conditioning stage that sits directly upstream of the edge detector. It synchronises an asynchronous raw input (button/external line) into the clk domain and rejects glitches with a counter-based debounce FSM. It then presents a clean registered level whose single-cycle transitions the edge detector turns into pos/neg/both pulses. It also exposes a stable flag and a saturating count of rejected glitches for debug.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops (legal 2..4).
DEBOUNCE_CYCLES, 4, samples the new level must persist beyond the first one (legal >= 1).
INIT_LEVEL, 0, reset value of synchroniser flops and out.
Derived localparam CNT_W = max(1, clog2(DEBOUNCE_CYCLES)) sizes the debounce counter. It is not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (asserted at 0).
in  input  1  raw asynchronous input.
glitch_clr  input  1  synchronous clear of glitch_cnt.
out  output  1  debounced registered level; feeds the edge detector's in.
stable  output  1  high while the FSM is in a STABLE state.
glitch_cnt  output  8  saturating count of rejected transitions.

Behaviour:
- Reset (rst=0, asynchronous): all sync flops = INIT_LEVEL; out = INIT_LEVEL; state = STABLE_HI if INIT_LEVEL else STABLE_LO; cnt = 0; stable = 1; glitch_cnt = 0. Reset asserted mid-CHECK aborts the check and the glitch is not counted. After release, the first clock edge operates normally.
- Synchroniser: in is shifted through SYNC_STAGES flops and s = last stage. in is never used combinationally.
- FSM has four states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
- STABLE_LO:
  - s=1 -> CHECK_HI, cnt <= 0.
  - otherwise stay.
- CHECK_HI:
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, out <= 1.
  - s=1 otherwise -> cnt <= cnt+1.
  - s=0 -> STABLE_LO, glitch_cnt increments.
- STABLE_HI and CHECK_LO mirror the above with polarity inverted.
- out changes only on CHECK->STABLE transitions, so it has at most one transition per accepted change and no chatter.
- stable = 1 in STABLE_LO/STABLE_HI and 0 in CHECK_*. It is registered, i.e. decoded from the state register.
- Acceptance rule: a new level must appear on s for DEBOUNCE_CYCLES+1 consecutive samples.
  - A raw pulse of P clock periods is accepted iff P >= DEBOUNCE_CYCLES+1.
  - Defaults: 4 cycles rejected, 5 accepted.
- Latency: if edge 0 is the first edge at which the sync stage-1 flop captures the new level, out changes at edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 6). stable falls at edge SYNC_STAGES (edge 2) and rises together with out.
- glitch_cnt:
  - +1 on every CHECK->STABLE return to the old level.
  - Saturates at 255 (no wrap).
  - glitch_clr=1 clears it to 0 on the next edge. A clear in the same cycle as a glitch event wins, giving 0.
- Bounce inside CHECK (s flips back) always returns to the originating STABLE state and never jumps straight to the opposite CHECK.
- DEBOUNCE_CYCLES=1: an accepted level needs 2 consecutive samples.

Test Plan:
1. Reset: hold rst=0, in=1 toggling -> out=0, stable=1, glitch_cnt=0 throughout. Release rst at 7ns; in=0 -> out stays 0.
2. Clean rise with defaults, 10ns clk: in 0->1 at 12ns and held -> stable=0 at edge 2, out=1 at edge 6 after the first capturing edge (stable=1 at the same edge), glitch_cnt=0. Then in 1->0 and held -> out=0 exactly 6 edges later.
3. Glitch rejection: in high for exactly 4 clocks then low -> out stays 0, stable returns to 1, glitch_cnt=1. Repeat with 5 clocks -> out=1 then 0, glitch_cnt unchanged.
4. Bouncing input: in toggles 1,0,1,0,1 each 2 cycles, then holds 1 -> glitch_cnt=2, out rises once, 6 edges after the final 0->1, with no intermediate pulses.
5. Saturation/clear: 260 short glitches -> glitch_cnt=255. Assert glitch_clr in the same cycle as a further glitch -> glitch_cnt=0.
6. Reset mid-CHECK: in held high, assert rst at edge 4 (state CHECK_HI) -> out=0, stable=1 immediately (asynchronous), glitch_cnt=0. Release with in still high -> out=1 at edge 6 after release.

Source files
------------

// File: rtl/sync_debounce.sv
// Input conditioning: multi-flop synchroniser followed by a counter-based
// debounce FSM that yields a clean level, a stable flag and a glitch count.
module sync_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit INIT_LEVEL      = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   input  logic       glitch_clr,
   output logic       out,
   output logic       stable,
   output logic [7:0] glitch_cnt
);

   localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      CHECK_HI  = 2'b01,
      STABLE_HI = 2'b11,
      CHECK_LO  = 2'b10
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_d;
   logic                   glitch;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   // Synchroniser chain; only the last stage is ever observed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
         cnt_q   <= '0;
         out     <= INIT_LEVEL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out     <= out_d;
      end
   end

   // A bounce in CHECK always falls back to the originating STABLE state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out;
      glitch  = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s) begin
               state_d = CHECK_HI;
               cnt_d   = '0;
            end
         end
         CHECK_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               glitch  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               out_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!s) begin
               state_d = CHECK_LO;
               cnt_d   = '0;
            end
         end
         CHECK_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               glitch  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               out_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign stable = (state_q == STABLE_LO) || (state_q == STABLE_HI);

   // Clear has priority over a coincident glitch; count saturates at 255.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             glitch_cnt <= '0;
      else if (glitch_clr)                  glitch_cnt <= '0;
      else if (glitch && glitch_cnt != '1)  glitch_cnt <= glitch_cnt + 8'd1;
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: stimulus queues expected out transitions
// (level + cycle) and glitch_cnt values; a negedge monitor pops and compares.
module tb_sync_debounce;
   logic       clk;
   logic       rst;
   logic       in;
   logic       glitch_clr;
   logic       out;
   logic       stable;
   logic [7:0] glitch_cnt;

   typedef struct {
      logic lvl;
      int   cyc;
   } out_ev_t;

   out_ev_t    out_q[$];
   logic [7:0] gc_q[$];
   int         cyc;
   int         vectors;
   int         miscompares;
   int         exp_gc;
   localparam int LAT = 7;  // negedge index of out change after driving in at negedge n

   sync_debounce dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .glitch_clr(glitch_clr),
      .out       (out),
      .stable    (stable),
      .glitch_cnt(glitch_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every change on out or glitch_cnt must match the next queued expectation.
   initial begin
      logic       prev_out;
      logic [7:0] prev_gc;
      out_ev_t    ev;
      logic [7:0] egc;
      prev_out = 1'b0;
      prev_gc  = 8'd0;
      forever begin
         @(negedge clk);
         if (out !== prev_out) begin
            vectors++;
            if (out_q.size() == 0) begin
               miscompares++;
               $display("FAIL out_unexpected: out=%b at cycle %0d, none expected", out, cyc);
            end else begin
               ev = out_q.pop_front();
               if (ev.lvl !== out || ev.cyc != cyc) begin
                  miscompares++;
                  $display("FAIL out_event: got level %b at cycle %0d, expected level %b at cycle %0d",
                           out, cyc, ev.lvl, ev.cyc);
               end
            end
            prev_out = out;
         end
         if (glitch_cnt !== prev_gc) begin
            vectors++;
            if (gc_q.size() == 0) begin
               miscompares++;
               $display("FAIL gc_unexpected: glitch_cnt=%0d at cycle %0d, none expected", glitch_cnt, cyc);
            end else begin
               egc = gc_q.pop_front();
               if (egc !== glitch_cnt) begin
                  miscompares++;
                  $display("FAIL gc_event: got %0d expected %0d at cycle %0d", glitch_cnt, egc, cyc);
               end
            end
            prev_gc = glitch_cnt;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic exp_glitch();
      if (exp_gc < 255) begin
         exp_gc++;
         gc_q.push_back(exp_gc[7:0]);
      end
   endtask

   task automatic exp_out(input logic lvl, input int c);
      out_ev_t ev;
      ev.lvl = lvl;
      ev.cyc = c;
      out_q.push_back(ev);
   endtask

   // One-cycle pulse with glitch_clr asserted on the edge where it is rejected.
   task automatic clr_with_glitch();
      in = 1'b1;
      idle(1);
      in = 1'b0;
      idle(2);
      exp_gc = 0;
      gc_q.push_back(8'd0);
      glitch_clr = 1'b1;
      idle(1);
      glitch_clr = 1'b0;
      idle(2);
   endtask

   initial begin
      int n;
      int m;
      vectors     = 0;
      miscompares = 0;
      exp_gc      = 0;
      rst         = 1'b0;
      in          = 1'b1;
      glitch_clr  = 1'b0;

      // 1. reset held while in toggles
      repeat (4) begin
         @(negedge clk);
         in = ~in;
         #2 in = ~in;
         #2;
         chk("rst_out", out, 0);
         chk("rst_stable", stable, 1);
         chk("rst_gc", glitch_cnt, 0);
      end
      @(negedge clk);
      in = 1'b0;
      #2 rst = 1'b1;
      idle(10);
      chk("post_rst_stable", stable, 1);

      // 2. clean rise then clean fall
      n = cyc;
      in = 1'b1;
      exp_out(1'b1, n + LAT);
      idle(2);
      chk("rise_stable_e1", stable, 1);
      idle(1);
      chk("rise_stable_e2", stable, 0);
      idle(3);
      chk("rise_stable_e5", stable, 0);
      idle(1);
      chk("rise_stable_e6", stable, 1);
      chk("rise_out_e6", out, 1);
      idle(3);
      n = cyc;
      in = 1'b0;
      exp_out(1'b0, n + LAT);
      idle(6);
      chk("fall_out_e5", out, 1);
      idle(1);
      chk("fall_out_e6", out, 0);
      chk("clean_gc", glitch_cnt, 0);
      idle(3);

      // 3. 4-cycle pulse rejected, 5-cycle pulse accepted
      in = 1'b1;
      exp_glitch();
      idle(4);
      in = 1'b0;
      idle(8);
      chk("p4_out", out, 0);
      chk("p4_stable", stable, 1);
      chk("p4_gc", glitch_cnt, 1);
      n = cyc;
      in = 1'b1;
      exp_out(1'b1, n + LAT);
      exp_out(1'b0, n + 5 + LAT);
      idle(5);
      in = 1'b0;
      idle(12);
      chk("p5_gc", glitch_cnt, 1);

      // 4. bouncing input then hold high
      exp_glitch();
      exp_glitch();
      in = 1'b1; idle(2);
      in = 1'b0; idle(2);
      in = 1'b1; idle(2);
      in = 1'b0; idle(2);
      n = cyc;
      in = 1'b1;
      exp_out(1'b1, n + LAT);
      idle(12);
      chk("bounce_gc", glitch_cnt, 3);
      chk("bounce_out", out, 1);
      m = cyc;
      in = 1'b0;
      exp_out(1'b0, m + LAT);
      idle(10);

      // 5. saturation, then clear colliding with a glitch
      for (int i = 0; i < 260; i++) begin
         in = 1'b1;
         exp_glitch();
         idle(1);
         in = 1'b0;
         idle(3);
      end
      chk("sat_gc", glitch_cnt, 255);
      clr_with_glitch();
      chk("sat_clr_gc", glitch_cnt, 0);
      in = 1'b1; exp_glitch(); idle(1); in = 1'b0; idle(4);
      chk("after_clr_gc", glitch_cnt, 1);
      clr_with_glitch();
      chk("clr_wins_gc", glitch_cnt, 0);
      in = 1'b1; exp_glitch(); idle(1); in = 1'b0; idle(4);

      // 6. reset asserted in CHECK_HI
      in = 1'b1;
      idle(5);
      chk("mid_check_stable", stable, 0);
      exp_gc = 0;
      gc_q.push_back(8'd0);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_out", out, 0);
      chk("async_rst_stable", stable, 1);
      chk("async_rst_gc", glitch_cnt, 0);
      idle(2);
      n = cyc;
      rst = 1'b1;
      exp_out(1'b1, n + LAT);
      idle(10);
      chk("rerise_out", out, 1);
      m = cyc;
      in = 1'b0;
      exp_out(1'b0, m + LAT);
      idle(10);

      chk("out_q_drained", out_q.size(), 0);
      chk("gc_q_drained", gc_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
